// File: rtl/mlp_ctrl_pkg.sv
// Shared definitions for the MLP accelerator control path: sequencer states,
// table defaults and the engine handshake widths used by the data mover too.
package mlp_ctrl_pkg;

    localparam int NUM_LAYER_DEF = 4;
    localparam int CNT_BIT_DEF   = 31;
    localparam int LW_DEF        = 2;
    localparam int ENG_RUN_W     = 1;
    localparam int ENG_DONE_W    = 1;
    localparam int BUSY_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Busy counter step that sticks at all-ones instead of wrapping.
    function automatic logic [BUSY_W-1:0] sat_inc(input logic [BUSY_W-1:0] v);
        if (v == {BUSY_W{1'b1}}) begin
            return v;
        end else begin
            return v + BUSY_W'(1);
        end
    endfunction

endpackage

// File: rtl/mlp_layer_seq_if.sv
// Run/idle/done handshake between the layer sequencer and the BRAM
// data-mover/compute engine.
interface mlp_layer_seq_if
    import mlp_ctrl_pkg::*;
#(
    parameter int CNT_BIT = CNT_BIT_DEF,
    parameter int LW      = LW_DEF
) ();

    logic [ENG_RUN_W-1:0]  o_eng_run;
    logic [CNT_BIT-1:0]    o_eng_num_cnt;
    logic [LW-1:0]         o_eng_layer;
    logic                  i_eng_idle;
    logic [ENG_DONE_W-1:0] i_eng_done;

    modport master (
        output o_eng_run, o_eng_num_cnt, o_eng_layer,
        input  i_eng_idle, i_eng_done
    );

    modport slave (
        input  o_eng_run, o_eng_num_cnt, o_eng_layer,
        output i_eng_idle, i_eng_done
    );

endinterface

// File: rtl/layer_cfg_regfile.sv
// Per-layer element-count table; host writes land only while the sequencer
// is idle so a running network never sees its counts change underneath it.
module layer_cfg_regfile #(
    parameter int NUM_LAYER = 4,
    parameter int CNT_BIT   = 31,
    parameter int LW        = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we_i,
    input  logic               idle_i,
    input  logic [LW-1:0]      wr_layer_i,
    input  logic [CNT_BIT-1:0] wr_cnt_i,
    input  logic [LW-1:0]      rd_layer_i,
    output logic [CNT_BIT-1:0] rd_cnt_o
);

    logic [CNT_BIT-1:0] cfg_q [NUM_LAYER];

    // Table storage, cleared by reset, written by the host when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LAYER; i++) begin
                cfg_q[i] <= '0;
            end
        end else if (we_i && idle_i) begin
            cfg_q[wr_layer_i] <= wr_cnt_i;
        end
    end

    assign rd_cnt_o = cfg_q[rd_layer_i];

endmodule

// File: rtl/mlp_layer_seq.sv
// Layer sequencer: walks layers 0..num-1, launching the engine once per
// non-empty layer, and reports one done for the whole network.
module mlp_layer_seq
    import mlp_ctrl_pkg::*;
#(
    parameter int CNT_BIT   = CNT_BIT_DEF,
    parameter int NUM_LAYER = NUM_LAYER_DEF,
    parameter int LW        = LW_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_cfg_we,
    input  logic [LW-1:0]      i_cfg_layer,
    input  logic [CNT_BIT-1:0] i_cfg_cnt,
    input  logic [LW:0]        i_num_layer,
    input  logic               i_run,
    output logic               o_idle,
    output logic               o_running,
    output logic               o_done,
    output logic               o_err,
    output logic [LW-1:0]      o_layer,
    output logic [BUSY_W-1:0]  o_busy_cycles,
    mlp_layer_seq_if.master    eng
);

    seq_state_e         state_q;
    logic [LW-1:0]      layer_q;
    logic [LW:0]        num_q;
    logic [BUSY_W-1:0]  busy_q;
    logic               done_q;
    logic               err_q;
    logic               eng_run_q;
    logic [CNT_BIT-1:0] eng_cnt_q;
    logic [LW-1:0]      eng_layer_q;

    logic               idle;
    logic               run_legal;
    logic               is_last;
    logic [LW:0]        last_idx;
    logic [CNT_BIT-1:0] cfg_cnt;

    layer_cfg_regfile #(
        .NUM_LAYER (NUM_LAYER),
        .CNT_BIT   (CNT_BIT),
        .LW        (LW)
    ) u_cfg (
        .clk        (clk),
        .reset_n    (reset_n),
        .we_i       (i_cfg_we),
        .idle_i     (idle),
        .wr_layer_i (i_cfg_layer),
        .wr_cnt_i   (i_cfg_cnt),
        .rd_layer_i (layer_q),
        .rd_cnt_o   (cfg_cnt)
    );

    assign idle      = (state_q == ST_IDLE);
    assign run_legal = (i_num_layer != '0) && (i_num_layer <= (LW+1)'(NUM_LAYER));
    assign last_idx  = num_q - (LW+1)'(1);
    assign is_last   = ({1'b0, layer_q} == last_idx);

    // Sequencer FSM with its counters and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            layer_q     <= '0;
            num_q       <= '0;
            busy_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            eng_run_q   <= 1'b0;
            eng_cnt_q   <= '0;
            eng_layer_q <= '0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            eng_run_q <= 1'b0;
            if (state_q != ST_IDLE) begin
                busy_q <= sat_inc(busy_q);
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_run && run_legal) begin
                        num_q   <= i_num_layer;
                        layer_q <= '0;
                        busy_q  <= '0;
                        state_q <= ST_ISSUE;
                    end else if (i_run) begin
                        err_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // An empty layer advances exactly as if the engine had finished it.
                    if (cfg_cnt == '0) begin
                        if (is_last) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            layer_q <= layer_q + LW'(1);
                        end
                    end else if (eng.i_eng_idle) begin
                        eng_run_q   <= 1'b1;
                        eng_cnt_q   <= cfg_cnt;
                        eng_layer_q <= layer_q;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng.i_eng_done != '0) begin
                        if (is_last) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            layer_q <= layer_q + LW'(1);
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_idle            = idle;
    assign o_running         = ~idle;
    assign o_done            = done_q;
    assign o_err             = err_q;
    assign o_layer           = layer_q;
    assign o_busy_cycles     = busy_q;
    assign eng.o_eng_run     = eng_run_q;
    assign eng.o_eng_num_cnt = eng_cnt_q;
    assign eng.o_eng_layer   = eng_layer_q;

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Scoreboard bench for mlp_layer_seq: a layer-list reference model predicts
// engine launches, done/err pulses and busy-cycle totals.
module tb_mlp_layer_seq;

    logic        clk;
    logic        reset_n;
    logic        i_cfg_we;
    logic [1:0]  i_cfg_layer;
    logic [30:0] i_cfg_cnt;
    logic [2:0]  i_num_layer;
    logic        i_run;
    logic        o_idle;
    logic        o_running;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_layer;
    logic [31:0] o_busy_cycles;
    logic        idle_hold;
    logic        eng_done_mdl;
    logic        eng_done_spur;

    typedef struct packed {
        logic [30:0] cnt;
        logic [1:0]  layer;
    } run_t;

    run_t        exp_run_q [$];
    int          exp_done_q [$];
    int          exp_err_q [$];
    logic [30:0] mdl_cfg [4];
    int          vectors = 0;
    int          miscompares = 0;
    int          eng_lat = 0;
    int          busy_exp = 0;
    bit          busy_chk_pending = 1'b0;

    mlp_layer_seq_if #(.CNT_BIT(31), .LW(2)) eng_if ();

    assign eng_if.i_eng_idle = ~idle_hold;
    assign eng_if.i_eng_done = eng_done_mdl | eng_done_spur;

    mlp_layer_seq #(.CNT_BIT(31), .NUM_LAYER(4), .LW(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_cfg_we      (i_cfg_we),
        .i_cfg_layer   (i_cfg_layer),
        .i_cfg_cnt     (i_cfg_cnt),
        .i_num_layer   (i_num_layer),
        .i_run         (i_run),
        .o_idle        (o_idle),
        .o_running     (o_running),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_layer       (o_layer),
        .o_busy_cycles (o_busy_cycles),
        .eng           (eng_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: answers each launch with a done pulse eng_lat cycles later.
    initial begin
        eng_done_mdl = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_if.o_eng_run == 1'b1) begin
                repeat (eng_lat) @(negedge clk);
                eng_done_mdl = 1'b1;
                @(negedge clk);
                eng_done_mdl = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference: a legal run launches every non-empty layer below num in order;
    // each launched layer costs issue + (lat+1) wait cycles, an empty one a
    // single cycle, plus one done cycle.
    task automatic start_run(input int num, input int lat, input bit trk);
        int   busy;
        run_t r;
        eng_lat = lat;
        if (num < 1 || num > 4) begin
            exp_err_q.push_back(1);
        end else begin
            busy = 1;
            for (int i = 0; i < num; i++) begin
                if (mdl_cfg[i] == 31'd0) begin
                    busy += 1;
                end else begin
                    r.cnt   = mdl_cfg[i];
                    r.layer = i[1:0];
                    exp_run_q.push_back(r);
                    busy += lat + 2;
                end
            end
            exp_done_q.push_back(trk ? busy : -1);
        end
        i_num_layer = num[2:0];
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
    endtask

    task automatic cfg_write(input int layer, input logic [30:0] cnt, input bit taken);
        i_cfg_we    = 1'b1;
        i_cfg_layer = layer[1:0];
        i_cfg_cnt   = cnt;
        if (taken) mdl_cfg[layer] = cnt;
        @(negedge clk);
        i_cfg_we = 1'b0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_run_q.size() != 0 || exp_done_q.size() != 0 || exp_err_q.size() != 0
                || busy_chk_pending) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d runs/%0d dones/%0d errs outstanding, required 0",
                     exp_run_q.size(), exp_done_q.size(), exp_err_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic monitor();
        run_t r;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (busy_chk_pending) begin
                    busy_chk_pending = 1'b0;
                    chk("idle_after_done", 64'(o_idle), 64'd1);
                    if (busy_exp >= 0) chk("busy_cycles", 64'(o_busy_cycles), 64'(busy_exp));
                end
                if (eng_if.o_eng_run == 1'b1) begin
                    if (exp_run_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_eng_run: got o_eng_run=1 layer %0d, required 0",
                                 eng_if.o_eng_layer);
                    end else begin
                        r = exp_run_q.pop_front();
                        chk("eng_num_cnt", 64'(eng_if.o_eng_num_cnt), 64'(r.cnt));
                        chk("eng_layer", 64'(eng_if.o_eng_layer), 64'(r.layer));
                    end
                end
                if (o_done) begin
                    if (exp_done_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: got o_done=1, required 0");
                    end else begin
                        busy_exp = exp_done_q.pop_front();
                        busy_chk_pending = 1'b1;
                    end
                end
                if (o_err) begin
                    if (exp_err_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_err: got o_err=1, required 0");
                    end else begin
                        void'(exp_err_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        int n;
        // Network of four layers, 20-cycle engine, first-launch latency.
        cfg_write(0, 31'd4096, 1'b1);
        cfg_write(1, 31'd256, 1'b1);
        cfg_write(2, 31'd64, 1'b1);
        cfg_write(3, 31'd10, 1'b1);
        start_run(4, 20, 1'b1);
        chk("issue_running", 64'(o_running), 64'd1);
        chk("no_run_in_issue", 64'(eng_if.o_eng_run), 64'd0);
        @(negedge clk);
        chk("eng_run_at_n2", 64'(eng_if.o_eng_run), 64'd1);
        drain(400);

        // Empty layer 1 is skipped in one cycle.
        cfg_write(1, 31'd0, 1'b1);
        start_run(3, 4, 1'b1);
        drain(200);

        // Illegal layer counts.
        start_run(0, 0, 1'b0);
        chk("idle_on_err0", 64'(o_idle), 64'd1);
        drain(20);
        start_run(5, 0, 1'b0);
        chk("idle_on_err5", 64'(o_idle), 64'd1);
        drain(20);

        // Engine busy for 50 cycles, with a stray done while issuing.
        cfg_write(1, 31'd256, 1'b1);
        idle_hold = 1'b1;
        start_run(2, 3, 1'b0);
        for (int i = 0; i < 50; i++) begin
            eng_done_spur = (i == 10);
            @(negedge clk);
            if (i % 10 == 9) chk("run_withheld", 64'(eng_if.o_eng_run), 64'd0);
        end
        eng_done_spur = 1'b0;
        chk("layer_after_spur", 64'(o_layer), 64'd0);
        chk("running_while_held", 64'(o_running), 64'd1);
        idle_hold = 1'b0;
        drain(200);

        // Config write and second run during WAIT are dropped.
        start_run(4, 10, 1'b1);
        n = 0;
        while (eng_if.o_eng_run != 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_first_run", 64'(n < 50), 64'd1);
        @(negedge clk);
        cfg_write(0, 31'd999, 1'b0);
        i_num_layer = 3'd2;
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        drain(400);
        start_run(4, 2, 1'b1);
        drain(200);

        // Randomized tables, counts and engine latencies.
        for (int t = 0; t < 8; t++) begin
            for (int l = 0; l < 4; l++) begin
                cfg_write(l, ($urandom_range(2) == 0) ? 31'd0 : 31'($urandom()), 1'b1);
            end
            start_run(int'($urandom_range(5)), int'($urandom_range(7)), 1'b1);
            drain(300);
        end

        // Reset during layer 2's WAIT.
        cfg_write(0, 31'd100, 1'b1);
        cfg_write(1, 31'd200, 1'b1);
        cfg_write(2, 31'd300, 1'b1);
        cfg_write(3, 31'd400, 1'b1);
        start_run(4, 5, 1'b1);
        n = 0;
        while (!(eng_if.o_eng_run == 1'b1 && eng_if.o_eng_layer == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_layer2", 64'(n < 100), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        exp_run_q.delete();
        exp_done_q.delete();
        busy_chk_pending = 1'b0;
        #1;
        chk("rst_idle", 64'(o_idle), 64'd1);
        chk("rst_flags", 64'({o_running, o_done, o_err, eng_if.o_eng_run}), 64'd0);
        chk("rst_layer", 64'(o_layer), 64'd0);
        chk("rst_busy", 64'(o_busy_cycles), 64'd0);
        chk("rst_eng_cnt", 64'(eng_if.o_eng_num_cnt), 64'd0);
        chk("rst_eng_layer", 64'(eng_if.o_eng_layer), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int l = 0; l < 4; l++) mdl_cfg[l] = 31'd0;
        repeat (12) @(negedge clk);
        start_run(4, 3, 1'b1);
        drain(100);
        cfg_write(0, 31'd7, 1'b1);
        cfg_write(2, 31'd9, 1'b1);
        cfg_write(3, 31'd11, 1'b1);
        start_run(4, 6, 1'b1);
        drain(200);

        chk("runs_left", 64'(exp_run_q.size()), 64'd0);
        chk("dones_left", 64'(exp_done_q.size()), 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        i_cfg_we      = 1'b0;
        i_cfg_layer   = 2'd0;
        i_cfg_cnt     = 31'd0;
        i_num_layer   = 3'd0;
        i_run         = 1'b0;
        idle_hold     = 1'b0;
        eng_done_spur = 1'b0;
        for (int l = 0; l < 4; l++) mdl_cfg[l] = 31'd0;
        repeat (3) @(negedge clk);
        chk("reset_idle", 64'(o_idle), 64'd1);
        chk("reset_running", 64'(o_running), 64'd0);
        chk("reset_busy", 64'(o_busy_cycles), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mlp_layer_seq.md
# mlp_layer_seq

Layer sequencer for the MLP accelerator. It holds a per-layer element-count table and runs the BRAM data-mover/compute engine once per layer through its run/idle/done handshake. Layers run in order from 0 to the requested count. The block sits between the host control registers and the engine: the host issues one start, and the block reports a single done when the whole network has finished.

## Interface
Parameters:
- CNT_BIT, 31: width of the per-layer element count.
- NUM_LAYER, 4: number of layer slots in the config table.
- LW, 2: layer index width, equal to clog2(NUM_LAYER).

Ports:
- clk, input, 1: clock. Single clock domain.
- reset_n, input, 1: reset, asynchronous and active-low.
- i_cfg_we, input, 1: config table write strobe.
- i_cfg_layer, input, LW: layer slot to write.
- i_cfg_cnt, input, CNT_BIT: element count for that slot.
- i_num_layer, input, LW+1: number of layers to run, legal range 1..NUM_LAYER.
- i_run, input, 1: start pulse from the host.
- o_idle, output, 1: sequencer idle.
- o_running, output, 1: sequence in progress.
- o_done, output, 1: one-cycle pulse when the whole sequence is complete.
- o_err, output, 1: one-cycle pulse when i_run arrives with an illegal i_num_layer.
- o_layer, output, LW: index of the current layer.
- o_busy_cycles, output, 32: number of non-IDLE cycles in the last run, saturating.
- o_eng_run, output, 1: one-cycle start pulse to the engine.
- o_eng_num_cnt, output, CNT_BIT: element count for the engine.
- o_eng_layer, output, LW: layer index for the engine, used to select weight and bias banks.
- i_eng_idle, input, 1: engine idle.
- i_eng_done, input, 1: engine done pulse.

## Operation
- The config table has NUM_LAYER entries of CNT_BIT bits each.
  - It resets to 0.
  - It is written only while the state is IDLE. Writes in any other state are dropped.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - o_idle=1.
  - If i_run=1 and 1 ≤ i_num_layer ≤ NUM_LAYER: latch num, clear layer and o_busy_cycles, go to ISSUE.
  - If i_run=1 with an illegal i_num_layer: pulse o_err and stay in IDLE.
- ISSUE:
  - If cfg[layer]==0, the layer is skipped: no engine run, advance directly (the same rule as a done in WAIT).
  - Otherwise, wait for i_eng_idle=1. Then assert o_eng_run for one cycle, load o_eng_num_cnt=cfg[layer] and o_eng_layer=layer, and go to WAIT.
- WAIT:
  - On i_eng_done: if layer==num-1, go to DONE; otherwise increment layer and go to ISSUE.
- DONE: o_done=1 for one cycle, then go to IDLE.
- Ignored inputs:
  - i_run outside IDLE.
  - i_eng_done outside WAIT.
- o_running = (state != IDLE).
- o_busy_cycles increments on every non-IDLE cycle, saturates at 2^32-1, and holds its value in IDLE.
- o_eng_num_cnt and o_eng_layer are registered and hold stable from the o_eng_run pulse until the next issue.
- Reset mid-run: everything returns to reset values immediately, the config table is cleared, and no o_done is produced. The engine is reset by the same reset_n.

## Timing
- Reset values:
  - o_idle=1.
  - Zero: o_running, o_done, o_err, o_layer, o_busy_cycles, o_eng_run, o_eng_num_cnt, o_eng_layer.
  - State=IDLE.
- i_run sampled at edge N: ISSUE during cycle N+1. With i_eng_idle=1 sampled at N+1, o_eng_run is high during N+2 and the state is WAIT.
- i_eng_done sampled at edge M in WAIT:
  - Next layer: ISSUE at M+1, o_eng_run at M+2 at the earliest.
  - Last layer: o_done high during M+1, o_idle high at M+2.
- A skipped (zero-count) layer costs exactly one ISSUE cycle.
- A config write is visible to a run started on the next cycle.
- o_err is asserted in the cycle after the illegal i_run.
- o_idle and o_running are decoded from the registered state. All other outputs are registered.

## Structure
- A shared package `mlp_ctrl_pkg` holds:
  - the state enum;
  - NUM_LAYER and CNT_BIT defaults;
  - the engine handshake width constants, shared with the data mover.
- The config table is a natural sub-module: `layer_cfg_regfile`, a NUM_LAYER x CNT_BIT register file with reset, a write enable gated by idle, and a combinational read. The FSM and counters stay in the top level.

## Test plan
- Write cfg={4096,256,64,10}, num_layer=4, run; the engine model answers done 20 cycles after each run → four o_eng_run pulses with counts 4096/256/64/10 and layers 0..3, then a single o_done and o_idle.
- cfg[1]=0, num_layer=3 → only layers 0 and 2 run; layer 1 costs one ISSUE cycle; o_done follows layer 2's done.
- num_layer=0, then num_layer=5 → an o_err pulse each time, o_eng_run never asserts, o_idle stays 1.
- Hold i_eng_idle=0 for 50 cycles after run → o_eng_run is withheld until idle rises, then pulses once. A spurious i_eng_done during ISSUE is ignored.
- A cfg write and a second i_run while in WAIT are both dropped: the table is unchanged after done and only one o_done is produced.
- reset_n low during WAIT of layer 2 → all outputs at reset values, cfg reads 0, no o_done. A fresh config-and-run afterwards completes normally and o_busy_cycles matches the cycle count.
